mult_div_sequencer: RTL

Iterative signed multiply/divide engine with its own sequencing FSM, serving the multicycle CPU's `mult`/`div` instructions. The main control unit issues a one-cycle `start` with the operation code on `mult_div`, then holds its own FSM in a wait state until `done` rises. The block latches both operands, runs a 32-step shift-add or restoring-divide loop, applies sign correction and writes the HI/LO registers, which the register-write path reads through `hi_lo`-selected muxing.

---
 rtl/mult_div_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_sequencer.sv
// Iterative signed 32x32 multiply / 32/32 divide with its own sequencer.
// Ports: clock, reset (async high), start, mult_div[1:0], a, b -> busy, done, div0, hi, lo.
module mult_div_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mult_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        is_div_q, is_div_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div0_q, div0_d;

  logic [32:0] mul_sum;
  logic [63:0] div_sh;
  logic [32:0] div_diff;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = div0_q;

    // Multiply: a_q is the multiplicand, b_q shifts out multiplier bits.
    mul_sum  = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
    // Divide: acc holds {rem, quot}; dividend starts in the low half.
    div_sh   = {acc_q[62:0], 1'b0};
    div_diff = {1'b0, div_sh[63:32]} - {1'b0, b_q};

    a_mag = sa_q ? (~a_q + 32'd1) : a_q;
    b_mag = sb_q ? (~b_q + 32'd1) : b_q;
    prod  = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
    quo   = (sa_q ^ sb_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem   = sa_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    unique case (state_q)
      S_IDLE: begin
        div0_d = 1'b0;
        if (start) begin
          if (mult_div == 2'b01 ||
              (mult_div == 2'b10 && b != 32'd0)) begin
            state_d  = S_PREP;
            a_d      = a;
            b_d      = b;
            is_div_d = mult_div[1];
            sa_d     = a[31];
            sb_d     = b[31];
          end else if (mult_div == 2'b10) begin
            state_d = S_DONE;
            div0_d  = 1'b1;
          end
        end
      end
      S_PREP: begin
        a_d     = a_mag;
        b_d     = b_mag;
        acc_d   = is_div_q ? {32'd0, a_mag} : 64'd0;
        cnt_d   = 5'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = div_diff[32] ? div_sh
                               : {div_diff[31:0], div_sh[31:1], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
          b_d   = {1'b0, b_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        div0_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = (state_q == S_PREP) || (state_q == S_RUN) ||
                (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
